// File: rtl/uart_pkg.sv
// Shared types and defaults for the FIFO-fed UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam int   CLKS_PER_BIT_DEF = 868;
  localparam logic IDLE_LVL         = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the terminal count.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = en && !clr && (cnt_q == TERM);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a registered-output sync FIFO into a UART line: start, LSB-first data,
// optional even parity, 1 or 2 stop bits.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  tick, cnt_clr, cnt_en;

  // Clearing in LOAD phase-aligns every frame to its start bit.
  assign cnt_clr = (state_q == LOAD);
  assign cnt_en  = (state_q == START) || (state_q == DATA) ||
                   (state_q == PARITY) || (state_q == STOP);

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= IDLE_LVL;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    case (state_q)
      IDLE:  if (!fifo_empty) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d = fifo_dout;
        par_d   = ^fifo_dout;
        bit_d   = '0;
        state_d = START;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        if (bit_q == LAST_DATA) begin
          bit_d   = '0;
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      PARITY: if (tick) state_d = STOP;
      STOP: if (tick) begin
        if (bit_q == LAST_STOP) begin
          bit_d   = '0;
          state_d = fifo_empty ? IDLE : FETCH;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level follows the next state so tx stays a plain register output.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = IDLE_LVL;
    endcase
  end

  always_comb begin
    fifo_rd_en = (state_q == FETCH);
    busy       = (state_q != IDLE);
    tx_done    = (state_q == STOP) && tick && (bit_q == LAST_STOP);
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Two transmitters (8N1 and 8E2) fed by behavioural FIFOs, checked by a mid-bit line monitor.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       wr0 = 1'b0, wr1 = 1'b0;
  logic [7:0] din0 = '0, din1 = '0;
  logic       empty0 = 1'b1, empty1 = 1'b1;
  logic [7:0] dout0 = '0, dout1 = '0;
  logic       rd0, rd1, tx0, tx1, busy0, busy1, done0, done1;

  logic [7:0] fq0[$], fq1[$], exp0[$], exp1[$];
  int st_q0[$], st_q1[$], dn_q0[$], dn_q1[$];
  int cyc = 0;
  int n_chk = 0, n_err = 0;
  int rd_cnt[2];
  int last_rd[2];
  int fall_cyc[2];
  logic prev_empty[2] = '{1'b1, 1'b1};

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .fifo_empty(empty0), .fifo_dout(dout0),
    .fifo_rd_en(rd0), .tx(tx0), .busy(busy0), .tx_done(done0)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .fifo_empty(empty1), .fifo_dout(dout1),
    .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .tx_done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] mk_line(input logic [7:0] d, input int k);
    logic [11:0] l;
    l      = '0;
    l[8:1] = d;
    if (k != 0) begin
      l[9]  = ^d;
      l[10] = 1'b1;
      l[11] = 1'b1;
    end else begin
      l[9] = 1'b1;
    end
    return l;
  endfunction

  // Upstream FIFOs: registered read data, empty flag updated at the clock edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd0 && fq0.size() > 0) dout0 <= fq0.pop_front();
    if (wr0) fq0.push_back(din0);
    empty0 <= (fq0.size() == 0);
    if (rd1 && fq1.size() > 0) dout1 <= fq1.pop_front();
    if (wr1) fq1.push_back(din1);
    empty1 <= (fq1.size() == 0);
  end

  always @(negedge clk) begin
    if (rd0) begin chk("pop_empty0", empty0, 0); rd_cnt[0]++; last_rd[0] = cyc; end
    if (rd1) begin chk("pop_empty1", empty1, 0); rd_cnt[1]++; last_rd[1] = cyc; end
    if (done0) dn_q0.push_back(cyc);
    if (done1) dn_q1.push_back(cyc);
    if (prev_empty[0] && !empty0) fall_cyc[0] = cyc;
    if (prev_empty[1] && !empty1) fall_cyc[1] = cyc;
    prev_empty[0] = empty0;
    prev_empty[1] = empty1;
  end

  task automatic mon(input int k);
    int nb;
    logic [11:0] line;
    logic [7:0] d;
    logic ok_done, abort, t, dn;
    nb = 10 + 2 * k;
    forever begin
      @(negedge clk);
      t = (k != 0) ? tx1 : tx0;
      if (!rst && t == 1'b0) begin
        if (k != 0) st_q1.push_back(cyc); else st_q0.push_back(cyc);
        line = '0; ok_done = 1'b1; abort = 1'b0;
        for (int off = 0; off < nb * CPB; off++) begin
          if (off > 0) @(negedge clk);
          if (rst) begin abort = 1'b1; break; end
          t  = (k != 0) ? tx1 : tx0;
          dn = (k != 0) ? done1 : done0;
          if (off % CPB == CPB / 2) line[off / CPB] = t;
          if (dn !== (off == nb * CPB - 1)) ok_done = 1'b0;
        end
        if (abort) begin
          if (k != 0) begin if (exp1.size() > 0) void'(exp1.pop_front()); end
          else begin if (exp0.size() > 0) void'(exp0.pop_front()); end
        end else begin
          chk($sformatf("sb_has_entry%0d", k), ((k != 0) ? exp1.size() : exp0.size()) > 0, 1);
          if ((k != 0) ? (exp1.size() > 0) : (exp0.size() > 0)) begin
            d = (k != 0) ? exp1.pop_front() : exp0.pop_front();
            chk($sformatf("line%0d_%02h", k, d), line, mk_line(d, k));
            chk($sformatf("done_pos%0d_%02h", k, d), ok_done, 1);
          end
        end
      end
    end
  endtask

  task automatic push(input int k, input logic [7:0] d);
    if (k != 0) begin wr1 = 1'b1; din1 = d; exp1.push_back(d); end
    else        begin wr0 = 1'b1; din0 = d; exp0.push_back(d); end
    @(negedge clk);
    wr0 = 1'b0;
    wr1 = 1'b0;
  endtask

  task automatic clr_stats();
    rd_cnt = '{0, 0};
    st_q0.delete(); st_q1.delete(); dn_q0.delete(); dn_q1.delete();
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (n < 3000 && !(((k != 0) ? exp1.size() : exp0.size()) == 0 &&
                         ((k != 0) ? busy1 : busy0) == 1'b0)) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle_timeout%0d", k), n < 3000, 1);
  endtask

  initial begin
    int w;
    fork
      mon(0);
      mon(1);
    join_none

    // Reset and idle
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tx0", tx0, 1);   chk("rst_busy0", busy0, 0); chk("rst_rd0", rd0, 0);
    chk("rst_tx1", tx1, 1);   chk("rst_busy1", busy1, 0); chk("rst_done0", done0, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_rd", rd_cnt[0] + rd_cnt[1], 0);
    chk("idle_busy0", busy0, 0);
    chk("idle_tx0", tx0, 1);

    // Single byte and latency
    clr_stats();
    push(0, 8'hA5);
    wait_idle(0);
    chk("t2_rd", rd_cnt[0], 1);
    chk("t2_done", dn_q0.size(), 1);
    chk("t2_lat_rd", last_rd[0] - fall_cyc[0], 1);
    chk("t2_lat_tx", st_q0.size() > 0 ? st_q0[0] - last_rd[0] : -1, 2);
    chk("t2_busy", busy0, 0);

    // Burst of five
    clr_stats();
    for (int i = 1; i <= 5; i++) push(0, 8'(i));
    wait_idle(0);
    chk("t3_rd", rd_cnt[0], 5);
    chk("t3_frames", st_q0.size(), 5);
    if (st_q0.size() == 5 && dn_q0.size() == 5)
      for (int i = 1; i < 5; i++) chk($sformatf("t3_gap%0d", i), st_q0[i] - dn_q0[i-1], 3);
    chk("t3_empty", empty0, 1);

    // Write during a frame
    clr_stats();
    push(0, 8'h11);
    w = 0;
    while (st_q0.size() == 0 && w < 200) begin @(negedge clk); w++; end
    chk("t6_start", st_q0.size() > 0, 1);
    repeat (10) @(negedge clk);
    push(0, 8'h3C);
    wait_idle(0);
    chk("t6_rd", rd_cnt[0], 2);
    chk("t6_gap", (st_q0.size() == 2 && dn_q0.size() == 2) ? st_q0[1] - dn_q0[0] : -1, 3);

    // Parity and two stop bits
    clr_stats();
    push(1, 8'h07);
    push(1, 8'h03);
    wait_idle(1);
    chk("t4_rd", rd_cnt[1], 2);
    chk("t4_frames", dn_q1.size(), 2);
    if (st_q1.size() == 2 && dn_q1.size() == 2) begin
      chk("t4_len0", dn_q1[0] - st_q1[0], 12 * CPB - 1);
      chk("t4_len1", dn_q1[1] - st_q1[1], 12 * CPB - 1);
      chk("t4_gap", st_q1[1] - dn_q1[0], 3);
    end

    // Reset in DATA bit 3
    clr_stats();
    push(0, 8'h5A);
    push(0, 8'h66);
    push(0, 8'h99);
    w = 0;
    while (tx0 && w < 200) begin @(negedge clk); w++; end
    chk("t5_start", tx0, 0);
    repeat (CPB + 3 * CPB + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_tx", tx0, 1);
    chk("t5_busy", busy0, 0);
    chk("t5_rd", rd0, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_idle(0);
    chk("t5_pops", rd_cnt[0], 3);
    chk("t5_frames", st_q0.size(), 3);
    chk("t5_empty", empty0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
